// File: rtl/balance_checker_pkg.sv
// Shared ALU/checker definitions.
//  - OP_CNT: opcode of the ALU ones-count operation; the checker accepts only this one.
//  - ST_*  : 2-bit state encodings of the balance_checker FSM.
package balance_checker_pkg;

    localparam logic [5:0] OP_CNT    = 6'b001000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

endpackage

// File: rtl/balance_checker_balance.sv
// balance_of_count: balance bit of a 4-bit ones count.
//  c : in  4  ones count (3-bit count zero-padded to 4 bits)
//  b : out 1  1 when c has an even number of set bits, else 0
module balance_of_count (
    input  logic [3:0] c,
    output logic       b
);

    assign b = ~(^c);

endmodule

// File: rtl/balance_checker.sv
// balance_checker: receive-side checker for the ALU ones-count result.
// Takes a word plus the sender's balance bit, recounts the ones one bit per
// clock, recomputes the balance bit and reports count, match flag and a
// saturating mismatch counter.
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      input word present
//  in_ready   out  1      high only in IDLE
//  opcode     in   6      word dropped unless equal to OP_CNT
//  data_in    in   W      word to count
//  balance_in in   1      sender's balance bit
//  out_valid  out  1      result valid (HOLD)
//  out_ready  in   1      consumer takes result
//  count_out  out  32     sign-extended 4-bit ones count
//  balance_ok out  1      recomputed balance == balance_in
//  err_cnt    out  ERR_W  saturating mismatch count
module balance_checker
    import balance_checker_pkg::*;
#(
    parameter int unsigned W      = 5,
    parameter logic [5:0]  OP     = OP_CNT,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [W-1:0]     data_in,
    input  logic             balance_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      count_out,
    output logic             balance_ok,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [2:0] K_LAST = 3'(W - 1);

    logic [1:0]   state;
    logic [W-1:0] sr;
    logic         bal_q;
    logic [2:0]   c;
    logic [2:0]   k;
    logic [3:0]   c4;
    logic         b;

    assign c4       = {1'b0, c};
    assign in_ready = (state == ST_IDLE);

    balance_of_count u_bal (
        .c (c4),
        .b (b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sr         <= '0;
            bal_q      <= 1'b0;
            c          <= '0;
            k          <= '0;
            out_valid  <= 1'b0;
            count_out  <= '0;
            balance_ok <= 1'b0;
            err_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Words with a foreign opcode are consumed and dropped.
                    if (in_valid && (opcode == OP)) begin
                        sr    <= data_in;
                        bal_q <= balance_in;
                        c     <= '0;
                        k     <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // LSB-first shift: sr[0] is data bit k this cycle.
                    sr <= sr >> 1;
                    c  <= c + {2'b00, sr[0]};
                    k  <= k + 3'd1;
                    if (k == K_LAST) begin
                        state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    count_out  <= {{28{c4[3]}}, c4};
                    balance_ok <= (b == bal_q);
                    if ((b != bal_q) && (err_cnt != '1)) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_balance_checker.sv
module tb_balance_checker;
    import balance_checker_pkg::*;

    localparam int unsigned W = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [4:0]  data_in;
    logic        balance_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] count_out;
    logic        balance_ok;
    logic [7:0]  err_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    balance_checker #(.W(5), .OP(OP_CNT), .ERR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .data_in    (data_in),
        .balance_in (balance_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count_out  (count_out),
        .balance_ok (balance_ok),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  data;
        logic        bal;
        logic [31:0] exp_count;
        logic        exp_ok;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs[7];

    // Reference balance table indexed by ones count (0..5).
    logic btab[6];

    logic [7:0] model_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Offer one word in IDLE; returns number of edges from acceptance to out_valid
    // (or -1 on timeout). Leaves the bench at the negedge where out_valid was seen.
    task automatic send(input logic [5:0] op, input logic [4:0] d, input logic bal, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        opcode     = op;
        data_in    = d;
        balance_in = bal;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    function automatic int popc(input logic [4:0] d);
        int s;
        s = 0;
        for (int i = 0; i < 5; i++) s += int'(d[i]);
        return s;
    endfunction

    initial begin
        int lat;
        logic [31:0] held_count;
        int cnt;
        logic expb;

        btab[0] = 1'b1; btab[1] = 1'b0; btab[2] = 1'b0;
        btab[3] = 1'b1; btab[4] = 1'b0; btab[5] = 1'b1;

        vecs[0] = '{OP_CNT, 5'b10110, 1'b1, 32'd3, 1'b1, 8'd0};
        vecs[1] = '{OP_CNT, 5'b11111, 1'b0, 32'd5, 1'b0, 8'd1};
        vecs[2] = '{OP_CNT, 5'b00000, 1'b1, 32'd0, 1'b1, 8'd1};
        vecs[3] = '{OP_CNT, 5'b00001, 1'b0, 32'd1, 1'b1, 8'd1};
        vecs[4] = '{OP_CNT, 5'b11011, 1'b0, 32'd4, 1'b1, 8'd1};
        vecs[5] = '{OP_CNT, 5'b00110, 1'b1, 32'd2, 1'b0, 8'd2};
        vecs[6] = '{OP_CNT, 5'b01110, 1'b1, 32'd3, 1'b1, 8'd2};

        rst = 1'b1; in_valid = 1'b0; opcode = '0; data_in = '0;
        balance_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},   32'd1);
        check("rst_out_valid", {31'd0, out_valid},  32'd0);
        check("rst_count",     count_out,           32'd0);
        check("rst_ok",        {31'd0, balance_ok}, 32'd0);
        check("rst_err",       {24'd0, err_cnt},    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors with latency check.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].op, vecs[i].data, vecs[i].bal, lat);
            check("latency",   lat,                        W + 1);
            check("count_out", count_out,                  vecs[i].exp_count);
            check("bal_ok",    {31'd0, balance_ok},        {31'd0, vecs[i].exp_ok});
            check("err_cnt",   {24'd0, err_cnt},           {24'd0, vecs[i].exp_err});
            check("hold_in_ready", {31'd0, in_ready},      32'd0);
            @(negedge clk);
            check("released",  {31'd0, out_valid},         32'd0);
        end

        // Foreign opcode: dropped, outputs unchanged for 20 clocks.
        in_valid = 1'b1; opcode = 6'b000001; data_in = 5'b11111; balance_in = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b1 || count_out !== 32'd3
                    || balance_ok !== 1'b1 || err_cnt !== 8'd2) bad++;
                @(negedge clk);
            end
            check("bad_opcode_quiet", bad, 0);
        end

        // Backpressure: hold for 10 clocks with a competing word offered.
        out_ready = 1'b0;
        send(OP_CNT, 5'b10101, 1'b1, lat);
        check("bp_latency", lat, W + 1);
        check("bp_count", count_out, 32'd3);
        held_count = count_out;
        in_valid = 1'b1; opcode = OP_CNT; data_in = 5'b00011; balance_in = 1'b0;
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || count_out !== held_count) bad++;
            end
            check("bp_stable", bad, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {31'd0, out_valid}, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < W + 4; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("bp_not_accepted", seen, 0);
        end
        check("bp_count_kept", count_out, 32'd3);

        // Reset on the third SHIFT cycle abandons the word.
        in_valid = 1'b1; opcode = OP_CNT; data_in = 5'b01011; balance_in = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst_err",       {24'd0, err_cnt},   32'd0);
        check("midrst_count",     count_out,          32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("midrst_no_result", seen, 0);
        end

        // Sweep all words x balance against the reference table.
        model_err = 8'd0;
        for (int d = 0; d < 32; d++) begin
            for (int bl = 0; bl < 2; bl++) begin
                cnt  = popc(5'(d));
                expb = btab[cnt];
                if (expb != 1'(bl) && model_err != 8'hFF) model_err++;
                send(OP_CNT, 5'(d), 1'(bl), lat);
                check("sweep_count", count_out, 32'(cnt));
                check("sweep_ok", {31'd0, balance_ok}, {31'd0, (expb == 1'(bl))});
                check("sweep_err", {24'd0, err_cnt}, {24'd0, model_err});
                @(negedge clk);
            end
        end

        // 260 mismatching words saturate the counter.
        for (int i = 0; i < 260; i++) begin
            send(OP_CNT, 5'b10110, 1'b0, lat);
            if (model_err != 8'hFF) model_err++;
            @(negedge clk);
        end
        check("sat_model", {24'd0, model_err}, 32'd255);
        check("sat_err", {24'd0, err_cnt}, 32'd255);
        check("sat_ok", {31'd0, balance_ok}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
